pi_loop_ctrl: RTL and testbench

Sample sequencer and state holder wrapped around the 6-stage PI pipeline. It accepts ADC sample strobes and presents one stable operand set per sample to the pipeline. It waits out the pipeline latency, writes the clamped updated integral back into its own accumulator register, and hands `pi_result` to the DAC writer over a valid/ready handshake. It sits between the ADC reader (upstream) and the PI pipeline plus DAC writer (downstream).

---
 rtl/pi_loop_ctrl_pkg.sv | 20 ++
 rtl/pi_loop_ctrl_if.sv | 22 ++
 rtl/pi_loop_ctrl_signed_clamp.sv | 21 ++
 rtl/pi_loop_ctrl.sv | 155 +++++++++++++++
 tb/tb_pi_loop_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pi_loop_ctrl_pkg.sv
// rtl/pi_loop_ctrl_pkg.sv - shared types and constants for the PI loop sequencer
package pi_loop_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Width of the dropped-strobe counter
  localparam int DROP_W = 16;

  // Counter width able to hold 0..latency inclusive
  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/pi_loop_ctrl_if.sv
// rtl/pi_loop_ctrl_if.sv - DAC output valid/ready channel
interface pi_loop_ctrl_if #(
  parameter int OUTPUT_WIDTH = 32
);
  logic signed [OUTPUT_WIDTH-1:0] dac_data;
  logic                           dac_valid;
  logic                           dac_ready;

  // Producer side: the loop controller
  modport master (
    output dac_data,
    output dac_valid,
    input  dac_ready
  );

  // Consumer side: the DAC writer
  modport slave (
    input  dac_data,
    input  dac_valid,
    output dac_ready
  );
endinterface

// File: rtl/pi_loop_ctrl_signed_clamp.sv
// rtl/pi_loop_ctrl_signed_clamp.sv - combinational signed saturation to [LO, HI]
module signed_clamp #(
  parameter int                       WIDTH = 32,
  parameter logic signed [WIDTH-1:0]  LO    = {1'b1, {(WIDTH-1){1'b0}}},
  parameter logic signed [WIDTH-1:0]  HI    = {1'b0, {(WIDTH-1){1'b1}}}
) (
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  // Pass through unless outside the window, then pin to the nearer bound
  always_comb begin
    dout = din;
    if (din > HI) begin
      dout = HI;
    end else if (din < LO) begin
      dout = LO;
    end
  end

endmodule

// File: rtl/pi_loop_ctrl.sv
// rtl/pi_loop_ctrl.sv - sample sequencer and integral holder around the PI pipeline
module pi_loop_ctrl
  import pi_loop_ctrl_pkg::*;
#(
  parameter int                             INPUT_WIDTH    = 18,
  parameter int                             OUTPUT_WIDTH   = 32,
  parameter int                             PIPE_LATENCY   = 6,
  parameter logic signed [OUTPUT_WIDTH-1:0] INTEGRAL_LIMIT = 32'sh0FFFFFFF
) (
  input  logic                           clk,
  input  logic                           rst_L,
  input  logic                           enable,
  input  logic                           integral_clear,
  input  logic signed [INPUT_WIDTH-1:0]  setpoint,
  input  logic signed [OUTPUT_WIDTH-1:0] kp,
  input  logic signed [OUTPUT_WIDTH-1:0] ki,
  input  logic signed [INPUT_WIDTH-1:0]  adc_data,
  input  logic                           adc_strobe,
  output logic signed [INPUT_WIDTH-1:0]  pipe_setpoint,
  output logic signed [INPUT_WIDTH-1:0]  pipe_actual,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_kp,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_ki,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_integral,
  input  logic signed [OUTPUT_WIDTH-1:0] pipe_integral_result,
  input  logic signed [OUTPUT_WIDTH-1:0] pipe_pi_result,
  pi_loop_ctrl_if.master                 dac,
  output logic signed [OUTPUT_WIDTH-1:0] integral_out,
  output logic                           busy,
  output logic [DROP_W-1:0]              drop_count
);

  localparam int CNT_W = cnt_width(PIPE_LATENCY);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic signed [OUTPUT_WIDTH-1:0] acc_q;
  logic signed [OUTPUT_WIDTH-1:0] acc_clamped;
  logic signed [OUTPUT_WIDTH-1:0] dac_data_q;
  logic [DROP_W-1:0]              drop_q;
  logic                           accept;
  logic                           capture;

  // Anti-windup limit applied to the integral coming back from the pipeline
  signed_clamp #(
    .WIDTH (OUTPUT_WIDTH),
    .LO    (-INTEGRAL_LIMIT),
    .HI    (INTEGRAL_LIMIT)
  ) u_clamp (
    .din  (pipe_integral_result),
    .dout (acc_clamped)
  );

  // State register
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus accept/capture strobes; a strobe in WAIT beats enable going low
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc_strobe) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(PIPE_LATENCY)) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (dac.dac_ready) state_d = enable ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latency counter: restarts on accept, counts edges while the pipeline settles
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Operand holding registers, frozen from accept until the next accept
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      pipe_actual   <= '0;
      pipe_setpoint <= '0;
      pipe_kp       <= '0;
      pipe_ki       <= '0;
    end else if (accept) begin
      pipe_actual   <= adc_data;
      pipe_setpoint <= setpoint;
      pipe_kp       <= kp;
      pipe_ki       <= ki;
    end
  end

  // Integral accumulator: clamped write-back on capture, clear only while idle
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      acc_q <= '0;
    end else if (capture) begin
      acc_q <= acc_clamped;
    end else if (state_q == ST_IDLE && integral_clear) begin
      acc_q <= '0;
    end
  end

  // DAC output register, held through backpressure
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      dac_data_q <= '0;
    end else if (capture) begin
      dac_data_q <= pipe_pi_result;
    end
  end

  // Saturating count of strobes that arrive while a sample is in flight
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      drop_q <= '0;
    end else if (adc_strobe && (state_q == ST_RUN || state_q == ST_OUT)
                 && drop_q != {DROP_W{1'b1}}) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign pipe_integral = acc_q;
  assign integral_out  = acc_q;
  assign dac.dac_data  = dac_data_q;
  assign dac.dac_valid = (state_q == ST_OUT);
  assign busy          = (state_q != ST_IDLE);
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_pi_loop_ctrl.sv
// tb/tb_pi_loop_ctrl.sv - self-checking bench for pi_loop_ctrl
module tb_pi_loop_ctrl;

  localparam longint LIM = 1000;

  logic               clk;
  logic               rst_L;
  logic               enable;
  logic               integral_clear;
  logic signed [17:0] setpoint;
  logic signed [31:0] kp;
  logic signed [31:0] ki;
  logic signed [17:0] adc_data;
  logic               adc_strobe;
  logic signed [17:0] pipe_setpoint;
  logic signed [17:0] pipe_actual;
  logic signed [31:0] pipe_kp;
  logic signed [31:0] pipe_ki;
  logic signed [31:0] pipe_integral;
  logic signed [31:0] pipe_integral_result;
  logic signed [31:0] pipe_pi_result;
  logic signed [31:0] integral_out;
  logic               busy;
  logic [15:0]        drop_count;

  pi_loop_ctrl_if #(.OUTPUT_WIDTH(32)) dac ();

  pi_loop_ctrl #(
    .INPUT_WIDTH    (18),
    .OUTPUT_WIDTH   (32),
    .PIPE_LATENCY   (6),
    .INTEGRAL_LIMIT (32'sd1000)
  ) dut (
    .clk                  (clk),
    .rst_L                (rst_L),
    .enable               (enable),
    .integral_clear       (integral_clear),
    .setpoint             (setpoint),
    .kp                   (kp),
    .ki                   (ki),
    .adc_data             (adc_data),
    .adc_strobe           (adc_strobe),
    .pipe_setpoint        (pipe_setpoint),
    .pipe_actual          (pipe_actual),
    .pipe_kp              (pipe_kp),
    .pipe_ki              (pipe_ki),
    .pipe_integral        (pipe_integral),
    .pipe_integral_result (pipe_integral_result),
    .pipe_pi_result       (pipe_pi_result),
    .dac                  (dac),
    .integral_out         (integral_out),
    .busy                 (busy),
    .drop_count           (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in 6-stage PI pipeline: integral += error, out = kp*error + ki*integral
  logic signed [31:0] m_err, m_ir, m_pi;
  logic signed [31:0] sh_pi [0:5];
  logic signed [31:0] sh_ir [0:5];

  always_comb begin
    m_err = 32'(pipe_actual) - 32'(pipe_setpoint);
    m_ir  = pipe_integral + m_err;
    m_pi  = pipe_kp * m_err + pipe_ki * m_ir;
  end

  always @(posedge clk) begin
    sh_pi[0] <= m_pi;
    sh_ir[0] <= m_ir;
    for (int i = 1; i < 6; i++) begin
      sh_pi[i] <= sh_pi[i-1];
      sh_ir[i] <= sh_ir[i-1];
    end
  end

  assign pipe_pi_result       = sh_pi[5];
  assign pipe_integral_result = sh_ir[5];

  int     total = 0;
  int     bad   = 0;
  longint acc_m = 0;
  int     drop_m = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint clamp_m(input longint v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  // One sample from WAIT through the DAC handshake, with optional stall and dropped strobes
  task automatic do_sample(input logic signed [17:0] adc, input logic signed [17:0] sp,
                           input int kp_i, input int ki_i, input int stall, input int drops,
                           input logic en_at_accept, input logic en_after);
    longint err, ir, exp_pi, exp_acc;
    int n;
    logic signed [31:0] hold;
    logic stable_ok;
    err     = longint'(adc) - longint'(sp);
    ir      = acc_m + err;
    exp_pi  = longint'(kp_i) * err + longint'(ki_i) * ir;
    exp_acc = clamp_m(ir);

    adc_data = adc; setpoint = sp; kp = kp_i; ki = ki_i;
    enable = en_at_accept; adc_strobe = 1'b1;
    tick();
    adc_strobe = 1'b0;
    total++;
    if (pipe_actual !== adc || pipe_setpoint !== sp) begin
      bad++; $display("FAIL latch_adc got=%0d/%0d exp=%0d/%0d", pipe_actual, pipe_setpoint, adc, sp);
    end
    total++;
    if (pipe_kp !== kp_i || pipe_ki !== ki_i || pipe_integral !== acc_m[31:0]) begin
      bad++; $display("FAIL latch_gain got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                      pipe_kp, pipe_ki, pipe_integral, kp_i, ki_i, acc_m);
    end
    adc_data = 18'($urandom); setpoint = 18'($urandom); kp = $urandom; ki = $urandom;
    enable = en_after;

    n = 0;
    while (dac.dac_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n != 7) begin
      bad++; $display("FAIL latency got=%0d exp=7", n);
    end
    total++;
    if (dac.dac_data !== exp_pi[31:0]) begin
      bad++; $display("FAIL dac_data got=%0d exp=%0d", dac.dac_data, exp_pi);
    end
    total++;
    if (integral_out !== exp_acc[31:0]) begin
      bad++; $display("FAIL integral_out got=%0d exp=%0d", integral_out, exp_acc);
    end
    acc_m = exp_acc;

    hold = dac.dac_data;
    stable_ok = 1'b1;
    dac.dac_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      adc_strobe = (i % 2 == 0 && i < 2 * drops);
      if (adc_strobe) drop_m++;
      tick();
      if (dac.dac_data !== hold || dac.dac_valid !== 1'b1) stable_ok = 1'b0;
    end
    adc_strobe = 1'b0;
    total++;
    if (stable_ok !== 1'b1) begin
      bad++; $display("FAIL dac_hold got=%0d exp=%0d", dac.dac_data, hold);
    end
    total++;
    if (drop_count !== 16'(drop_m)) begin
      bad++; $display("FAIL drop_count got=%0d exp=%0d", drop_count, drop_m);
    end
    dac.dac_ready = 1'b1;
    tick();
    dac.dac_ready = 1'b0;
    total++;
    if (dac.dac_valid !== 1'b0 || busy !== en_after) begin
      bad++; $display("FAIL post_handshake got=valid%0d/busy%0d exp=valid0/busy%0d",
                      dac.dac_valid, busy, en_after);
    end
  endtask

  task automatic go_idle_and_clear();
    enable = 1'b0;
    tick();
    integral_clear = 1'b1;
    tick();
    integral_clear = 1'b0;
    acc_m = 0;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_L = 1'b0; enable = 1'b0; integral_clear = 1'b0; adc_strobe = 1'b0;
    adc_data = '0; setpoint = '0; kp = '0; ki = '0; dac.dac_ready = 1'b0;
    repeat (2) tick();
    total++;
    if (busy !== 1'b0 || dac.dac_valid !== 1'b0 || dac.dac_data !== 32'sd0) begin
      bad++; $display("FAIL reset_out got=busy%0d/valid%0d/data%0d exp=0/0/0",
                      busy, dac.dac_valid, dac.dac_data);
    end
    total++;
    if (integral_out !== 32'sd0 || drop_count !== 16'd0 || pipe_actual !== 18'sd0 || pipe_kp !== 32'sd0) begin
      bad++; $display("FAIL reset_regs got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                      integral_out, drop_count, pipe_actual, pipe_kp);
    end
    rst_L = 1'b1;
    adc_strobe = 1'b1;
    tick();
    adc_strobe = 1'b0;
    total++;
    if (busy !== 1'b0 || drop_count !== 16'd0) begin
      bad++; $display("FAIL idle_strobe got=busy%0d/drop%0d exp=0/0", busy, drop_count);
    end
  endtask

  task automatic test_proportional();
    enable = 1'b1;
    tick();
    do_sample(18'sd100, 18'sd0, 1, 0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_integral();
    go_idle_and_clear();
    for (int s = 0; s < 4; s++) begin
      do_sample(18'sd5, 18'sd0, 0, 1, 0, 0, 1'b1, 1'b1);
      repeat (3) tick();
    end
    total++;
    if (integral_out !== 32'sd20) begin
      bad++; $display("FAIL integral_sum got=%0d exp=20", integral_out);
    end
  endtask

  task automatic test_anti_windup();
    int seq [8] = '{300, 300, 300, 300, 0, -2000, -1, 1};
    go_idle_and_clear();
    foreach (seq[i]) do_sample(18'(seq[i]), 18'sd0, 0, 1, 0, 0, 1'b1, 1'b1);
    total++;
    if (integral_out !== -32'sd999) begin
      bad++; $display("FAIL windup_final got=%0d exp=-999", integral_out);
    end
  endtask

  task automatic test_backpressure();
    do_sample(18'sd40, -18'sd10, 2, 1, 20, 3, 1'b1, 1'b1);
    do_sample(-18'sd7, 18'sd3, 1, 1, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_enable_clear();
    do_sample(18'sd50, 18'sd0, 1, 1, 2, 0, 1'b1, 1'b0);
    adc_strobe = 1'b1;
    tick();
    adc_strobe = 1'b0;
    total++;
    if (busy !== 1'b0 || drop_count !== 16'(drop_m)) begin
      bad++; $display("FAIL idle_ignore got=busy%0d/drop%0d exp=0/%0d", busy, drop_count, drop_m);
    end
    enable = 1'b1;
    tick();
    integral_clear = 1'b1;
    tick();
    integral_clear = 1'b0;
    total++;
    if (integral_out !== acc_m[31:0]) begin
      bad++; $display("FAIL clear_in_wait got=%0d exp=%0d", integral_out, acc_m);
    end
    enable = 1'b0;
    tick();
    integral_clear = 1'b1;
    tick();
    integral_clear = 1'b0;
    acc_m = 0;
    total++;
    if (integral_out !== 32'sd0 || busy !== 1'b0) begin
      bad++; $display("FAIL clear_idle got=%0d/busy%0d exp=0/0", integral_out, busy);
    end
    enable = 1'b1;
    tick();
    do_sample(18'sd9, 18'sd2, 1, 1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    tick();
    adc_data = 18'sd77; setpoint = 18'sd1; kp = 3; ki = 2;
    adc_strobe = 1'b1;
    tick();
    adc_strobe = 1'b0;
    repeat (3) tick();
    rst_L = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || dac.dac_valid !== 1'b0 || dac.dac_data !== 32'sd0 || drop_count !== 16'd0) begin
      bad++; $display("FAIL async_out got=busy%0d/valid%0d/data%0d/drop%0d exp=0/0/0/0",
                      busy, dac.dac_valid, dac.dac_data, drop_count);
    end
    total++;
    if (integral_out !== 32'sd0 || pipe_actual !== 18'sd0 || pipe_setpoint !== 18'sd0 || pipe_ki !== 32'sd0) begin
      bad++; $display("FAIL async_regs got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                      integral_out, pipe_actual, pipe_setpoint, pipe_ki);
    end
    tick();
    rst_L = 1'b1;
    acc_m = 0;
    drop_m = 0;
    tick();
    do_sample(18'sd33, -18'sd4, 2, 1, 1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      int a, p, g, h, st;
      logic ea, en;
      a  = int'($urandom_range(0, 3000)) - 1500;
      p  = int'($urandom_range(0, 3000)) - 1500;
      g  = int'($urandom_range(0, 16)) - 8;
      h  = int'($urandom_range(0, 8)) - 4;
      st = int'($urandom_range(0, 6));
      ea = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      do_sample(18'(a), 18'(p), g, h, st, st / 2, ea, en);
      enable = 1'b1;
      if (!en) tick();
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integral();
    test_anti_windup();
    test_backpressure();
    test_enable_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
